alu_unit: RTL and testbench

Registered 32-bit integer ALU for the KGP_RISC datapath: it computes add, two's-complement, logic, shift and 32×32 multiply operations on two operands selected by a 6-bit opcode. It sits in the execute stage between the register-file/immediate mux and the write-back/branch-flag logic. All results and status flags are registered once per clock.

---
 rtl/alu_if.sv | 27 ++
 rtl/alu_unit.sv | 118 +++++++++++
 tb/tb_alu_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/opcode and result/flag bundle for the execute-stage ALU.
// The master drives operands; the slave (alu_unit) returns the registered result.
interface alu_if;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned OW = 6;

  logic [DW-1:0] inp1;
  logic [DW-1:0] inp2;
  logic [OW-1:0] opcode;
  logic [DW-1:0] out;
  logic [PW-1:0] mulout;
  logic          carryFlag;
  logic          zFlag;
  logic          signFlag;
  logic          overflowFlag;

  modport master (
    output inp1, inp2, opcode,
    input  out, mulout, carryFlag, zFlag, signFlag, overflowFlag
  );

  modport slave (
    input  inp1, inp2, opcode,
    output out, mulout, carryFlag, zFlag, signFlag, overflowFlag
  );
endinterface

// File: rtl/alu_unit.sv
// Registered 32-bit KGP_RISC ALU: add, complement, logic, shifts and 32x32 multiply.
// Define ALU_MULT_EN to build the multiplier; otherwise mult/multu return zero.
module alu_unit (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned SW = 5;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_MULT  = 6'b000010;
  localparam logic [5:0] OP_MULTU = 6'b000011;
  localparam logic [5:0] OP_COMP  = 6'b000100;
  localparam logic [5:0] OP_COMPI = 6'b000101;
  localparam logic [5:0] OP_AND   = 6'b000110;
  localparam logic [5:0] OP_XOR   = 6'b000111;
  localparam logic [5:0] OP_SHLL  = 6'b001000;
  localparam logic [5:0] OP_SHRL  = 6'b001001;
  localparam logic [5:0] OP_SHLLV = 6'b001010;
  localparam logic [5:0] OP_SHRLV = 6'b001011;
  localparam logic [5:0] OP_SHRA  = 6'b001100;
  localparam logic [5:0] OP_SHRAV = 6'b001101;

  typedef struct packed {
    logic [DW-1:0] out;
    logic [PW-1:0] mulout;
    logic          carry;
    logic          zero;
    logic          sign;
    logic          ovf;
  } alu_res_t;

  alu_res_t res_q;
  alu_res_t res_c;

  logic [DW:0]   sum_c;
  logic [DW:0]   neg_c;
  logic [SW-1:0] shamt_c;
  logic [PW-1:0] prod_c;
  logic          is_mul_c;

  // Shared 33-bit adder results: A+B and ~B+1 (two's complement of B).
  assign sum_c   = {1'b0, bus.inp1} + {1'b0, bus.inp2};
  assign neg_c   = {1'b0, ~bus.inp2} + (DW+1)'(1);
  assign shamt_c = bus.inp2[SW-1:0];
  assign is_mul_c = (bus.opcode == OP_MULT) || (bus.opcode == OP_MULTU);

`ifdef ALU_MULT_EN
  logic               mul_sgn_c;
  logic signed [DW:0] mul_a_c;
  logic signed [DW:0] mul_b_c;
  logic signed [2*DW+1:0] mul_full_c;

  // One signed 33x33 multiplier serves both ops: unsigned operands get a zero top bit.
  assign mul_sgn_c  = (bus.opcode == OP_MULT);
  assign mul_a_c    = {mul_sgn_c & bus.inp1[DW-1], bus.inp1};
  assign mul_b_c    = {mul_sgn_c & bus.inp2[DW-1], bus.inp2};
  assign mul_full_c = mul_a_c * mul_b_c;
  assign prod_c     = mul_full_c[PW-1:0];
`else
  assign prod_c = '0;
`endif

  // Next-result selection and flag generation.
  always_comb begin
    res_c = '0;
    case (bus.opcode)
      OP_ADD, OP_ADDI: begin
        res_c.out   = sum_c[DW-1:0];
        res_c.carry = sum_c[DW];
        res_c.ovf   = (bus.inp1[DW-1] == bus.inp2[DW-1]) &&
                      (sum_c[DW-1] != bus.inp1[DW-1]);
      end
      OP_COMP, OP_COMPI: begin
        res_c.out   = neg_c[DW-1:0];
        res_c.carry = neg_c[DW];
        res_c.ovf   = bus.inp2[DW-1] & neg_c[DW-1];
      end
      OP_AND:            res_c.out = bus.inp1 & bus.inp2;
      OP_XOR:            res_c.out = bus.inp1 ^ bus.inp2;
      OP_SHLL, OP_SHLLV: res_c.out = bus.inp1 << shamt_c;
      OP_SHRL, OP_SHRLV: res_c.out = bus.inp1 >> shamt_c;
      OP_SHRA, OP_SHRAV: res_c.out = DW'($signed(bus.inp1) >>> shamt_c);
      OP_MULT, OP_MULTU: begin
        res_c.mulout = prod_c;
        res_c.out    = prod_c[DW-1:0];
      end
      default:           res_c.out = '0;
    endcase

    // Multiplies report status on the full product, everything else on out.
    if (is_mul_c) begin
      res_c.zero = (res_c.mulout == '0);
      res_c.sign = res_c.mulout[PW-1];
    end else begin
      res_c.zero = (res_c.out == '0);
      res_c.sign = res_c.out[DW-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_c;
    end
  end

  assign bus.out          = res_q.out;
  assign bus.mulout       = res_q.mulout;
  assign bus.carryFlag    = res_q.carry;
  assign bus.zFlag        = res_q.zero;
  assign bus.signFlag     = res_q.sign;
  assign bus.overflowFlag = res_q.ovf;
endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed corner cases plus randomized ops
// against an arithmetic reference model. Honours ALU_MULT_EN like the design.
module tb_alu_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_if bus ();

  alu_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] ops [16] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011,
                           6'b000100, 6'b000101, 6'b000110, 6'b000111,
                           6'b001000, 6'b001001, 6'b001010, 6'b001011,
                           6'b001100, 6'b001101, 6'b111111, 6'b010000};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model straight from the opcode rules, flags packed as {c,z,s,v}.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] o, output logic [63:0] m, output logic [3:0] f);
    logic [63:0] t;
    logic [31:0] p2;
    longint      sa;
    longint      sb;
    logic        c;
    logic        v;
    logic        mul;
    o = 32'd0; m = 64'd0; c = 1'b0; v = 1'b0; mul = 1'b0;
    p2 = 32'd1 << b[4:0];
    case (op)
      6'b000000, 6'b000001: begin
        t = {32'd0, a} + {32'd0, b};
        o = t[31:0];
        c = t[32];
        v = (a[31] == b[31]) && (o[31] != a[31]);
      end
      6'b000100, 6'b000101: begin
        o = 32'd0 - b;
        c = (b == 32'd0);
        v = (b == 32'h8000_0000);
      end
      6'b000110: o = a & b;
      6'b000111: o = a ^ b;
      6'b001000, 6'b001010: o = a * p2;
      6'b001001, 6'b001011: o = a / p2;
      6'b001100, 6'b001101: o = (a / p2) | (a[31] ? ~(32'hFFFF_FFFF / p2) : 32'd0);
      6'b000010: begin
        mul = 1'b1;
`ifdef ALU_MULT_EN
        sa = $signed(a);
        sb = $signed(b);
        m = 64'(sa * sb);
`endif
        o = m[31:0];
      end
      6'b000011: begin
        mul = 1'b1;
`ifdef ALU_MULT_EN
        m = {32'd0, a} * {32'd0, b};
`endif
        o = m[31:0];
      end
      default: o = 32'd0;
    endcase
    if (mul) f = {c, m == 64'd0, m[63], v};
    else     f = {c, o == 32'd0, o[31], v};
  endfunction

  // Present one op for one edge and compare all outputs just after that edge.
  task automatic do_op(input logic r, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eo;
    logic [63:0] em;
    logic [3:0]  ef;
    @(negedge clk);
    rst = r;
    bus.opcode = op;
    bus.inp1 = a;
    bus.inp2 = b;
    model(op, a, b, eo, em, ef);
    if (!r) begin
      eo = '0; em = '0; ef = '0;
    end
    @(posedge clk);
    #1;
    check_eq($sformatf("out op=%b r=%b", op, r), 64'(bus.out), 64'(eo));
    check_eq($sformatf("mulout op=%b r=%b", op, r), bus.mulout, em);
    check_eq($sformatf("flags op=%b r=%b", op, r),
             64'({bus.carryFlag, bus.zFlag, bus.signFlag, bus.overflowFlag}), 64'(ef));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [3:0] flags_now();
    return {bus.carryFlag, bus.zFlag, bus.signFlag, bus.overflowFlag};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.opcode = 6'd0;
    bus.inp1 = 32'd0;
    bus.inp2 = 32'd0;

    // Reset held for two edges with random inputs.
    do_op(1'b0, ops[$urandom_range(0, 15)], $urandom(), $urandom());
    do_op(1'b0, ops[$urandom_range(0, 15)], $urandom(), $urandom());
    check_eq("reset out", 64'(bus.out), 64'd0);

    do_op(1'b1, 6'b000001, 32'd0, 32'd7);
    check_eq("addi out", 64'(bus.out), 64'd7);
    check_eq("addi flags", 64'(flags_now()), 64'(4'b0000));

    do_op(1'b1, 6'b000000, 32'h0000_008B, 32'hFFFF_FFFF);
    check_eq("add carry out", 64'(bus.out), 64'h8A);
    check_eq("add carry flags", 64'(flags_now()), 64'(4'b1000));

    do_op(1'b1, 6'b000000, 32'h7FFF_FFFF, 32'd1);
    check_eq("add ovf out", 64'(bus.out), 64'h8000_0000);
    check_eq("add ovf flags", 64'(flags_now()), 64'(4'b0011));

    do_op(1'b1, 6'b000110, 32'h7FFE_07FF, 32'h7FFF_FFFF);
    check_eq("and out", 64'(bus.out), 64'h7FFE_07FF);

    do_op(1'b1, 6'b000101, 32'h1234_5678, 32'hFFFF_FFFC);
    check_eq("compi out", 64'(bus.out), 64'd4);

    do_op(1'b1, 6'b000100, 32'hDEAD_BEEF, 32'd0);
    check_eq("comp0 out", 64'(bus.out), 64'd0);
    check_eq("comp0 flags", 64'(flags_now()), 64'(4'b1100));

    do_op(1'b1, 6'b000100, 32'd0, 32'h8000_0000);
    check_eq("comp min flags", 64'(flags_now()), 64'(4'b0011));

    do_op(1'b1, 6'b001001, 32'h38FC_7038, 32'd11);
    check_eq("shrl out", 64'(bus.out), 64'h0007_1F8E);

    do_op(1'b1, 6'b001100, 32'hFC7E_381C, 32'd3);
    check_eq("shra out", 64'(bus.out), 64'hFF8F_C703);
    check_eq("shra sign", 64'(bus.signFlag), 64'd1);

    do_op(1'b1, 6'b001000, 32'd1, 32'd31);
    check_eq("shll out", 64'(bus.out), 64'h8000_0000);

    do_op(1'b1, 6'b001011, 32'h9234_5678, 32'h20);
    check_eq("shamt 0x20 pass", 64'(bus.out), 64'h9234_5678);

    do_op(1'b1, 6'b000010, 32'h78, 32'hFFFF_FFF6);
`ifdef ALU_MULT_EN
    check_eq("mult mulout", bus.mulout, 64'hFFFF_FFFF_FFFF_FB50);
    check_eq("mult sign", 64'(bus.signFlag), 64'd1);
`else
    check_eq("mult off mulout", bus.mulout, 64'd0);
    check_eq("mult off flags", 64'(flags_now()), 64'(4'b0100));
`endif

    do_op(1'b1, 6'b000011, 32'h78, 32'hFFFF_FFF6);
`ifdef ALU_MULT_EN
    check_eq("multu mulout", bus.mulout, 64'h0000_0077_FFFF_FB50);
    check_eq("multu sign", 64'(bus.signFlag), 64'd0);
`else
    check_eq("multu off mulout", bus.mulout, 64'd0);
`endif

    do_op(1'b1, 6'b111111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_eq("unlisted out", 64'(bus.out), 64'd0);

    // Walk every opcode back-to-back, one per cycle.
    for (int pass = 0; pass < 4; pass++) begin
      for (int k = 0; k < 16; k++) begin
        do_op(1'b1, ops[k], pick(), pick());
      end
    end

    // Randomized stream with occasional mid-stream resets.
    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic [5:0] op;
      r  = !((i % 53) == 17 || (i % 53) == 18);
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 13)];
      do_op(r, op, pick(), pick());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
